// File: rtl/reg_write_sequencer.sv
// -----------------------------------------------------------------------------
// reg_write_sequencer
//   Write-side front end for the register file. Destination writes arrive
//   over a valid/ready handshake and are buffered in a small FIFO. At most
//   one write per cycle is issued on the registered register-file write port
//   (IN / INaddr / WRITE). On request, the block drains the FIFO and then
//   sweeps CLR_VALUE into every register in address order.
//
// Ports
//   clk       in   clock, all state updates on posedge
//   RESET     in   synchronous active-high reset
//   wr_valid  in   write request valid
//   wr_ready  out  FIFO can accept (only while idle and not full)
//   wr_data   in   data to write
//   wr_addr   in   destination register
//   clr_req   in   clear-sweep request (level, sampled while idle)
//   clr_busy  out  clear pending or in progress
//   IN        out  register-file write data (registered)
//   INaddr    out  register-file write address (registered)
//   WRITE     out  register-file write enable, one-cycle pulse per write
//   pending   out  FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module reg_write_sequencer #(
  parameter int               DATA_W    = 8,
  parameter int               ADDR_W    = 3,
  parameter int               DEPTH     = 4,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [DATA_W-1:0] IN,
  output logic [ADDR_W-1:0] INaddr,
  output logic              WRITE,
  output logic [ADDR_W:0]   pending
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;

  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_REG   = '1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_sweep_addr;
  logic [DATA_W-1:0] r_in;
  logic [ADDR_W-1:0] r_inaddr;
  logic              r_write;
  logic              r_clr_busy;

  logic              w_full;
  logic              w_push;
  logic              w_pop;

  assign w_full   = (r_count == FULL_COUNT);
  // Ready depends only on registered state, never on wr_valid.
  assign wr_ready = (r_state == ST_IDLE) && !w_full;
  assign w_push   = wr_valid && wr_ready;
  // The FIFO keeps issuing while idle and while draining; the sweep owns the
  // write port exclusively.
  assign w_pop    = (r_state != ST_SWEEP) && (r_count != '0);

  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (clr_req) w_state_next = ST_DRAIN;
      // The DRAIN cycle that sees an empty FIFO issues nothing and hands over.
      ST_DRAIN: if (r_count == '0) w_state_next = ST_SWEEP;
      ST_SWEEP: if (r_sweep_addr == LAST_REG) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: FIFO storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= wr_data;
      r_mem_addr[r_wptr] <= wr_addr;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_sweep_addr <= '0;
      r_in         <= '0;
      r_inaddr     <= '0;
      r_write      <= 1'b0;
      r_clr_busy   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_write <= 1'b0;

      if (w_push) r_wptr <= r_wptr + 1'b1;

      if (w_pop) begin
        r_rptr   <= r_rptr + 1'b1;
        r_in     <= r_mem_data[r_rptr];
        r_inaddr <= r_mem_addr[r_rptr];
        r_write  <= 1'b1;
      end else if (r_state == ST_SWEEP) begin
        r_in         <= CLR_VALUE;
        r_inaddr     <= r_sweep_addr;
        r_write      <= 1'b1;
        // Wraps to 0 after the last register, ready for the next sweep.
        r_sweep_addr <= r_sweep_addr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Busy stays high through the cycle that shows the last sweep write.
      r_clr_busy <= (w_state_next != ST_IDLE) || (r_state == ST_SWEEP);
    end
  end

  assign IN       = r_in;
  assign INaddr   = r_inaddr;
  assign WRITE    = r_write;
  assign clr_busy = r_clr_busy;
  assign pending  = (ADDR_W+1)'(r_count);

endmodule

// File: tb/tb_reg_write_sequencer.sv
`timescale 1ns/1ps

module tb_reg_write_sequencer;

  localparam int         DATA_W    = 8;
  localparam int         ADDR_W    = 3;
  localparam int         DEPTH     = 4;
  localparam int         NREGS     = 2**ADDR_W;
  localparam logic [7:0] CLR_VALUE = 8'h00;

  logic              clk = 1'b0;
  logic              RESET;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              clr_req;
  logic              clr_busy;
  logic [DATA_W-1:0] IN;
  logic [ADDR_W-1:0] INaddr;
  logic              WRITE;
  logic [ADDR_W:0]   pending;

  always #5 clk = ~clk;

  reg_write_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLR_VALUE(CLR_VALUE)
  ) dut (
    .clk(clk), .RESET(RESET),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_addr(wr_addr),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .IN(IN), .INaddr(INaddr), .WRITE(WRITE), .pending(pending)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t               m_q[$];       // queued writes, head issues next
  bit                m_drain;      // clear requested, waiting for queue to empty
  int                m_sweep = -1; // next register to clear, -1 when not sweeping
  logic [DATA_W-1:0] m_in;
  logic [ADDR_W-1:0] m_addr;
  bit                m_write;
  bit                m_busy;
  bit                m_accepted;

  wr_t               log_q[$];     // writes seen on the DUT port, in order
  logic [DATA_W-1:0] shadow [NREGS];

  task automatic model_edge();
    bit  idle_ok;
    bit  finished;
    wr_t h;
    if (RESET) begin
      m_q.delete();
      m_drain = 0; m_sweep = -1; m_in = '0; m_addr = '0;
      m_write = 0; m_busy = 0; m_accepted = 0;
      return;
    end
    idle_ok    = !m_drain && (m_sweep < 0);
    m_accepted = wr_valid && idle_ok && (m_q.size() < DEPTH);
    finished   = 0;
    m_write    = 0;
    if (m_sweep >= 0) begin
      m_write = 1; m_in = CLR_VALUE; m_addr = ADDR_W'(m_sweep);
      m_sweep++;
      if (m_sweep == NREGS) begin m_sweep = -1; finished = 1; end
    end else begin
      if (m_q.size() > 0) begin
        h = m_q.pop_front();
        m_write = 1; m_in = h.d; m_addr = h.a;
      end else if (m_drain) begin
        m_drain = 0; m_sweep = 0;
      end
      if (idle_ok && clr_req) m_drain = 1;
    end
    if (m_accepted) m_q.push_back({wr_addr, wr_data});
    m_busy = m_drain || (m_sweep >= 0) || finished;
  endtask

  // One clock: drive inputs, let the edge happen, then compare everything.
  task automatic step(input bit rst, input bit v, input logic [7:0] d,
                      input logic [2:0] a, input bit clr);
    RESET = rst; wr_valid = v; wr_data = d; wr_addr = a; clr_req = clr;
    @(posedge clk);
    model_edge();
    #1;
    if (WRITE === 1'b1) begin
      shadow[INaddr] = IN;
      log_q.push_back({INaddr, IN});
    end
    check("WRITE", 32'(WRITE), 32'(m_write));
    check("IN", 32'(IN), 32'(m_in));
    check("INaddr", 32'(INaddr), 32'(m_addr));
    check("clr_busy", 32'(clr_busy), 32'(m_busy));
    check("pending", 32'(pending), 32'(m_q.size()));
    check("wr_ready", 32'(wr_ready),
          32'(!m_drain && (m_sweep < 0) && (m_q.size() < DEPTH)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0);
  endtask

  // Holds the request until it transfers, as the upstream does.
  task automatic push_hold(input logic [7:0] d, input logic [2:0] a, input bit clr);
    int n = 0;
    do begin
      step(0, 1, d, a, clr);
      n++;
    end while (!m_accepted && n < 50);
    if (!m_accepted) begin
      n_compared++; n_mismatched++;
      $display("FAIL push_timeout: observed no transfer expected transfer within 50 cycles");
    end
  endtask

  initial begin
    int  n;
    bit  have_req;
    logic [7:0] rd;
    logic [2:0] ra;

    for (int i = 0; i < NREGS; i++) shadow[i] = '0;

    // Reset state
    step(1, 0, '0, '0, 0);
    step(1, 0, '0, '0, 0);
    check("rst_WRITE", 32'(WRITE), 0);
    check("rst_IN", 32'(IN), 0);
    check("rst_INaddr", 32'(INaddr), 0);
    check("rst_busy", 32'(clr_busy), 0);
    check("rst_ready", 32'(wr_ready), 1);
    check("rst_pending", 32'(pending), 0);

    // Single write: accepted at edge 1, on the port after edge 2, gone after edge 3
    step(0, 1, 8'h97, 3'b101, 0);
    check("t1_pending", 32'(pending), 1);
    check("t1_no_bypass", 32'(WRITE), 0);
    step(0, 0, '0, '0, 0);
    check("t1_WRITE", 32'(WRITE), 1);
    check("t1_IN", 32'(IN), 32'h97);
    check("t1_INaddr", 32'(INaddr), 32'h5);
    step(0, 0, '0, '0, 0);
    check("t1_WRITE_off", 32'(WRITE), 0);
    check("t1_IN_hold", 32'(IN), 32'h97);

    // Back-to-back burst of six writes, all issued in order
    log_q.delete();
    for (int i = 0; i < 6; i++) push_hold(8'h30 + 8'(i), 3'(i + 1), 0);
    idle(4);
    check("t2_count", 32'(log_q.size()), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      check($sformatf("t2_order%0d", i), 32'(log_q[i]), 32'({3'(i + 1), 8'h30 + 8'(i)}));

    // Queued writes followed by a clear sweep
    log_q.delete();
    push_hold(8'hA1, 3'd6, 0);
    push_hold(8'hA2, 3'd7, 0);
    push_hold(8'hA3, 3'd1, 1);
    n = 0;
    while (clr_busy === 1'b1 && n < 40) begin
      step(0, 0, '0, '0, 0);
      n++;
    end
    check("t3_busy_cycles", 32'(n), 11);
    check("t3_count", 32'(log_q.size()), 11);
    if (log_q.size() == 11) begin
      check("t3_w0", 32'(log_q[0]), 32'({3'd6, 8'hA1}));
      check("t3_w1", 32'(log_q[1]), 32'({3'd7, 8'hA2}));
      check("t3_w2", 32'(log_q[2]), 32'({3'd1, 8'hA3}));
      for (int i = 0; i < NREGS; i++)
        check($sformatf("t3_clr%0d", i), 32'(log_q[3 + i]), 32'({3'(i), CLR_VALUE}));
    end
    for (int i = 0; i < NREGS; i++)
      check($sformatf("t3_reg%0d", i), 32'(shadow[i]), 32'(CLR_VALUE));

    // Reset in the middle of a sweep
    step(0, 0, '0, '0, 1);
    n = 0;
    while (!(WRITE === 1'b1 && INaddr == 3'd3) && n < 30) begin
      step(0, 0, '0, '0, 0);
      n++;
    end
    check("t4_reached_addr3", 32'(INaddr), 3);
    step(1, 0, '0, '0, 0);
    check("t4_WRITE", 32'(WRITE), 0);
    check("t4_IN", 32'(IN), 0);
    check("t4_INaddr", 32'(INaddr), 0);
    check("t4_busy", 32'(clr_busy), 0);
    check("t4_pending", 32'(pending), 0);
    check("t4_ready", 32'(wr_ready), 1);
    idle(3);
    check("t4_no_write_after", 32'(WRITE), 0);

    // Push and pop every cycle: occupancy stays flat, data in order
    log_q.delete();
    step(0, 1, 8'h50, 3'd0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 8'h50 + 8'(i), 3'(i), 0);
      check($sformatf("t5_pending%0d", i), 32'(pending), 1);
    end
    idle(2);
    check("t5_count", 32'(log_q.size()), 11);
    for (int i = 0; i < 11 && i < log_q.size(); i++)
      check($sformatf("t5_order%0d", i), 32'(log_q[i].d), 32'(8'h50 + 8'(i)));

    // Same destination twice: last write wins
    push_hold(8'h11, 3'b010, 0);
    push_hold(8'h22, 3'b010, 0);
    idle(3);
    check("t6_reg2", 32'(shadow[2]), 32'h22);

    // Randomized traffic with occasional clears and resets
    have_req = 0; rd = '0; ra = '0;
    for (int i = 0; i < 400; i++) begin
      if (!have_req && ($urandom % 3 != 0)) begin
        have_req = 1;
        rd = 8'($urandom);
        ra = 3'($urandom);
      end
      if ($urandom % 150 == 0) begin
        step(1, 0, '0, '0, 0);
        have_req = 0;
      end else begin
        step(0, have_req, rd, ra, ($urandom % 24 == 0));
        if (m_accepted) have_req = 0;
      end
    end
    idle(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
